// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller for a 6502-style core.
// Arbitrates reset, NMI and NUM_IRQ maskable channels, presents the winning
// event to the core and holds it stable while the vector is fetched.
// Build option: define INT_CTRL_VECTORED_EN to give each IRQ channel its own
// vector at VEC_BASE + 2*i; otherwise every IRQ channel shares IRQ_VECTOR.
module int_ctrl #(
    parameter int unsigned        NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
    parameter logic [15:0]        NMI_VECTOR = 16'hfffa,
    parameter logic [15:0]        RST_VECTOR = 16'hfffc,
    parameter logic [15:0]        IRQ_VECTOR = 16'hfffe,
    parameter logic [15:0]        VEC_BASE   = 16'hffe0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nmi,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               i_flag,
    input  logic               sync,
    input  logic               rdy,
    input  logic               handle_int,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               int_req,
    output logic [1:0]         int_kind,
    output logic [15:0]        vector,
    output logic [3:0]         irq_id,
    output logic [NUM_IRQ-1:0] irq_en
);

`ifdef INT_CTRL_VECTORED_EN
    localparam logic VECTORED = 1'b1;
`else
    localparam logic VECTORED = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        TAKEN
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE = 2'b00,
        KIND_RST  = 2'b01,
        KIND_NMI  = 2'b10,
        KIND_IRQ  = 2'b11
    } kind_t;

    state_t state;
    state_t state_nxt;

    logic               rst_pend;
    logic               nmi_pend;
    logic               nmi_d;
    logic [NUM_IRQ-1:0] irq_d;
    logic [NUM_IRQ-1:0] pend;
    kind_t              kind_q;

    logic               ack;
    logic               ack_rst;
    logic               ack_nmi;
    logic               ack_irq;
    logic [NUM_IRQ-1:0] ack_ch;
    logic [NUM_IRQ-1:0] irq_rise;

    logic               rst_pend_nxt;
    logic               nmi_pend_nxt;
    logic [NUM_IRQ-1:0] pend_nxt;
    logic [NUM_IRQ-1:0] en_nxt;
    logic [NUM_IRQ-1:0] elig_nxt;
    logic               req_nxt;

    logic               found;
    logic [3:0]         low_idx;
    kind_t              win_kind;
    logic [15:0]        win_vec;
    logic [3:0]         win_id;

    assign int_kind = kind_q;

    assign ack     = (state == TAKEN) && handle_int;
    assign ack_rst = ack && (kind_q == KIND_RST);
    assign ack_nmi = ack && (kind_q == KIND_NMI);
    assign ack_irq = ack && (kind_q == KIND_IRQ);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: take on a ready opcode fetch, return on acknowledge
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sync && rdy && int_req) state_nxt = TAKEN;
            TAKEN:   if (handle_int)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next-cycle pending/enable view; int_req and the winner are registered
    // from this so an input change is visible after exactly one clock.
    always_comb begin
        ack_ch = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            ack_ch[i] = ack_irq && (irq_id == 4'(i));
        end
        irq_rise     = irq & ~irq_d;
        rst_pend_nxt = rst_pend && !ack_rst;
        nmi_pend_nxt = (nmi && !nmi_d) || (nmi_pend && !ack_nmi);
        // a new edge wins over a same-cycle acknowledge of that channel
        pend_nxt     = (EDGE_MASK & (irq_rise | (pend & ~ack_ch))) | (~EDGE_MASK & irq);
        en_nxt       = mask_we ? mask_wdata : irq_en;
        elig_nxt     = pend_nxt & en_nxt & {NUM_IRQ{!i_flag}};
        req_nxt      = rst_pend_nxt || nmi_pend_nxt || (|elig_nxt);
    end

    // Priority winner: RST, then NMI, then the lowest eligible IRQ index
    always_comb begin
        found   = 1'b0;
        low_idx = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (elig_nxt[i] && !found) begin
                found   = 1'b1;
                low_idx = 4'(i);
            end
        end
        win_kind = KIND_NONE;
        win_vec  = '0;
        win_id   = '0;
        if (rst_pend_nxt) begin
            win_kind = KIND_RST;
            win_vec  = RST_VECTOR;
        end else if (nmi_pend_nxt) begin
            win_kind = KIND_NMI;
            win_vec  = NMI_VECTOR;
        end else if (found) begin
            win_kind = KIND_IRQ;
            win_vec  = VECTORED ? (VEC_BASE + {11'b0, low_idx, 1'b0}) : IRQ_VECTOR;
            win_id   = low_idx;
        end
    end

    // Pending state, edge-detect history and the enable register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_pend <= 1'b1;
            nmi_pend <= 1'b0;
            nmi_d    <= 1'b0;
            irq_d    <= '0;
            pend     <= '0;
            irq_en   <= '1;
        end else begin
            rst_pend <= rst_pend_nxt;
            nmi_pend <= nmi_pend_nxt;
            nmi_d    <= nmi;
            irq_d    <= irq;
            pend     <= pend_nxt;
            irq_en   <= en_nxt;
        end
    end

    // Request and event outputs; frozen from the take until the return to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_req <= 1'b0;
            kind_q  <= KIND_NONE;
            vector  <= '0;
            irq_id  <= '0;
        end else begin
            int_req <= req_nxt;
            if (state_nxt == IDLE) begin
                kind_q <= win_kind;
                vector <= win_vec;
                irq_id <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: scoreboard bench for int_ctrl. Stimulus pushes the expected
// taken event; the monitor pops and compares whenever the core takes one.
// Channel 0 is rising-edge, channels 1..3 are level.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic        nmi;
    logic [3:0]  irq;
    logic        i_flag;
    logic        sync;
    logic        rdy;
    logic        handle_int;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic        int_req;
    logic [1:0]  int_kind;
    logic [15:0] vector;
    logic [3:0]  irq_id;
    logic [3:0]  irq_en;

    int tests;
    int failed;

`ifdef INT_CTRL_VECTORED_EN
    localparam logic [15:0] V0 = 16'hffe0;
    localparam logic [15:0] V1 = 16'hffe2;
    localparam logic [15:0] V2 = 16'hffe4;
    localparam logic [15:0] V3 = 16'hffe6;
`else
    localparam logic [15:0] V0 = 16'hfffe;
    localparam logic [15:0] V1 = 16'hfffe;
    localparam logic [15:0] V2 = 16'hfffe;
    localparam logic [15:0] V3 = 16'hfffe;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] vec;
        logic [3:0]  id;
    } exp_t;

    exp_t sb_q[$];

    int_ctrl #(
        .NUM_IRQ   (4),
        .EDGE_MASK (4'b0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nmi        (nmi),
        .irq        (irq),
        .i_flag     (i_flag),
        .sync       (sync),
        .rdy        (rdy),
        .handle_int (handle_int),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .int_req    (int_req),
        .int_kind   (int_kind),
        .vector     (vector),
        .irq_id     (irq_id),
        .irq_en     (irq_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] v, input logic [3:0] id);
        exp_t e;
        e.kind = k;
        e.vec  = v;
        e.id   = id;
        sb_q.push_back(e);
    endtask

    // Hold an opcode fetch until the controller requests, then let it take
    task automatic take();
        logic seen;
        seen = 1'b0;
        @(posedge clk);
        #1;
        sync = 1'b1;
        rdy  = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (int_req) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        sync = 1'b0;
        if (!seen) check("take_wait", {31'b0, seen}, 32'd1);
    endtask

    task automatic ack();
        handle_int = 1'b1;
        cyc(1);
        handle_int = 1'b0;
    endtask

    // Monitor: a take happens on the next edge; compare the presented event
    always @(negedge clk) begin
        if (rst && sync && rdy && int_req) begin
            if (sb_q.size() == 0) begin
                check("mon_unexpected_take", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mon_kind", {30'b0, int_kind}, {30'b0, e.kind});
                check("mon_vector", {16'b0, vector}, {16'b0, e.vec});
                check("mon_irq_id", {28'b0, irq_id}, {28'b0, e.id});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests      = 0;
        failed     = 0;
        rst        = 1'b0;
        nmi        = 1'b0;
        irq        = '0;
        i_flag     = 1'b0;
        sync       = 1'b0;
        rdy        = 1'b0;
        handle_int = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = '0;

        // reset state
        cyc(3);
        @(negedge clk);
        check("rst_int_req", {31'b0, int_req}, 32'd0);
        check("rst_int_kind", {30'b0, int_kind}, 32'd0);
        check("rst_vector", {16'b0, vector}, 32'd0);
        check("rst_irq_id", {28'b0, irq_id}, 32'd0);
        check("rst_irq_en", {28'b0, irq_en}, 32'hf);

        // release: RST request on the first clock
        cyc(1);
        rst = 1'b1;
        cyc(1);
        @(negedge clk);
        check("boot_int_req", {31'b0, int_req}, 32'd1);
        check("boot_kind", {30'b0, int_kind}, 32'd1);
        check("boot_vector", {16'b0, vector}, 32'h0000fffc);

        // rdy low stalls the take; handle_int in IDLE is ignored
        sync = 1'b1;
        rdy  = 1'b0;
        cyc(2);
        handle_int = 1'b1;
        cyc(1);
        handle_int = 1'b0;
        sync       = 1'b0;
        @(negedge clk);
        check("stall_int_req", {31'b0, int_req}, 32'd1);
        check("stall_kind", {30'b0, int_kind}, 32'd1);

        // RST taken and acknowledged
        push(2'b01, 16'hfffc, 4'd0);
        take();
        ack();
        @(negedge clk);
        check("rst_ack_int_req", {31'b0, int_req}, 32'd0);
        check("rst_ack_kind", {30'b0, int_kind}, 32'd0);

        // two level IRQs: lowest index first; masking the taken one holds it
        irq = 4'b0110;
        push(2'b11, V1, 4'd1);
        take();
        irq        = 4'b0100;
        mask_we    = 1'b1;
        mask_wdata = 4'b1101;
        cyc(1);
        mask_we = 1'b0;
        @(negedge clk);
        check("held_kind", {30'b0, int_kind}, 32'd3);
        check("held_irq_id", {28'b0, irq_id}, 32'd1);
        check("held_vector", {16'b0, vector}, {16'b0, V1});
        check("mask_1101", {28'b0, irq_en}, 32'hd);
        push(2'b11, V2, 4'd2);
        ack();
        take();
        irq        = 4'b0000;
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        cyc(1);
        mask_we = 1'b0;
        ack();
        @(negedge clk);
        check("irq2_done_int_req", {31'b0, int_req}, 32'd0);
        check("mask_1111", {28'b0, irq_en}, 32'hf);

        // level channel withdrawn before any fetch
        irq = 4'b1000;
        cyc(1);
        @(negedge clk);
        check("lvl_req_up", {31'b0, int_req}, 32'd1);
        check("lvl_irq_id", {28'b0, irq_id}, 32'd3);
        irq = 4'b0000;
        cyc(1);
        @(negedge clk);
        check("lvl_req_withdrawn", {31'b0, int_req}, 32'd0);
        check("lvl_kind_none", {30'b0, int_kind}, 32'd0);

        // NMI held high: one take only, then a second pulse takes again
        nmi = 1'b1;
        push(2'b10, 16'hfffa, 4'd0);
        take();
        ack();
        cyc(15);
        @(negedge clk);
        check("nmi_held_no_retrig", {31'b0, int_req}, 32'd0);
        nmi = 1'b0;
        cyc(2);
        nmi = 1'b1;
        push(2'b10, 16'hfffa, 4'd0);
        take();
        ack();
        nmi = 1'b0;
        @(negedge clk);
        check("nmi2_done_int_req", {31'b0, int_req}, 32'd0);

        // edge pulse while interrupts disabled stays pending
        i_flag = 1'b1;
        irq    = 4'b0001;
        cyc(1);
        irq = 4'b0000;
        cyc(3);
        @(negedge clk);
        check("iflag_blocks", {31'b0, int_req}, 32'd0);
        i_flag = 1'b0;
        push(2'b11, V0, 4'd0);
        take();
        ack();
        @(negedge clk);
        check("edge_cleared", {31'b0, int_req}, 32'd0);

        // NMI arriving during a taken IRQ 3 waits for the acknowledge
        irq = 4'b1000;
        push(2'b11, V3, 4'd3);
        take();
        nmi = 1'b1;
        cyc(2);
        @(negedge clk);
        check("taken3_kind", {30'b0, int_kind}, 32'd3);
        check("taken3_irq_id", {28'b0, irq_id}, 32'd3);
        check("taken3_vector", {16'b0, vector}, {16'b0, V3});
        push(2'b10, 16'hfffa, 4'd0);
        ack();
        take();
        irq = 4'b0000;
        nmi = 1'b0;
        cyc(1);
        ack();
        @(negedge clk);
        check("nmi_after_irq3_done", {31'b0, int_req}, 32'd0);

        // new edge in the acknowledge cycle of the same channel survives
        irq = 4'b0001;
        cyc(1);
        irq = 4'b0000;
        push(2'b11, V0, 4'd0);
        take();
        handle_int = 1'b1;
        irq        = 4'b0001;
        cyc(1);
        handle_int = 1'b0;
        irq        = 4'b0000;
        @(negedge clk);
        check("edge_ack_req", {31'b0, int_req}, 32'd1);
        check("edge_ack_kind", {30'b0, int_kind}, 32'd3);
        push(2'b11, V0, 4'd0);
        take();
        ack();
        @(negedge clk);
        check("edge_ack_done", {31'b0, int_req}, 32'd0);

        // masked channel 0 blocks; unmasking requests on the next clock
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        cyc(1);
        mask_we = 1'b0;
        @(negedge clk);
        check("mask_1110", {28'b0, irq_en}, 32'he);
        irq = 4'b0001;
        cyc(2);
        @(negedge clk);
        check("masked_no_req", {31'b0, int_req}, 32'd0);
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        cyc(1);
        mask_we = 1'b0;
        @(negedge clk);
        check("unmask_req", {31'b0, int_req}, 32'd1);
        push(2'b11, V0, 4'd0);
        take();
        irq = 4'b0000;
        ack();
        @(negedge clk);
        check("unmask_done", {31'b0, int_req}, 32'd0);

        // reset in TAKEN aborts, then RST is requested again
        irq = 4'b0100;
        push(2'b11, V2, 4'd2);
        take();
        rst = 1'b0;
        @(negedge clk);
        check("abort_int_req", {31'b0, int_req}, 32'd0);
        check("abort_kind", {30'b0, int_kind}, 32'd0);
        check("abort_vector", {16'b0, vector}, 32'd0);
        cyc(1);
        rst = 1'b1;
        irq = 4'b0000;
        cyc(1);
        @(negedge clk);
        check("reboot_kind", {30'b0, int_kind}, 32'd1);
        check("reboot_int_req", {31'b0, int_req}, 32'd1);
        push(2'b01, 16'hfffc, 4'd0);
        take();
        ack();
        @(negedge clk);
        check("reboot_done", {31'b0, int_req}, 32'd0);

        check("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
